// File: rtl/color_led_pkg.sv
// Shared types and saturating duty arithmetic for the color LED driver.
// color_t matches the upstream Color FSM output encoding.
package color_led_pkg;

    typedef enum logic [1:0] {
        NONE = 2'h0,
        BLUE = 2'h1,
        RED  = 2'h2
    } color_t;

    typedef enum logic [1:0] {
        IDLE,
        FADE_IN,
        STEADY,
        FADE_OUT
    } led_state_t;

    // The one-bit-wider sum cannot overflow, so the clamp is exact.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    function automatic logic is_legal(input logic [1:0] code);
        return (code == BLUE) || (code == RED);
    endfunction

endpackage

// File: rtl/color_led_driver_pwm_channel.sv
// One PWM LED output: high while the shared counter is below this channel's duty.
module led_pwm_channel #(
    parameter int unsigned PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PWM_WIDTH-1:0] pwm_cnt,
    input  logic [PWM_WIDTH-1:0] duty,
    input  logic                 pwm_en,
    output logic                 led
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= 1'b0;
        end else begin
            led <= pwm_en && (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/color_led_driver.sv
// Two-channel PWM LED driver that cross-fades between Blue and Red:
// the owning channel ramps down to zero before the new color ramps up.
module color_led_driver
    import color_led_pkg::*;
#(
    parameter int unsigned PWM_WIDTH = 8,
    parameter int unsigned FADE_STEP = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] color_in,
    input  logic       pwm_en,
    output logic       led_blue,
    output logic       led_red,
    output logic [1:0] cur_color,
    output logic       busy,
    output logic       err
);

    localparam logic [PWM_WIDTH-1:0] DUTY_MAX = '1;

    led_state_t           state;
    color_t               cur;
    color_t               pending;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [PWM_WIDTH-1:0] duty_blue;
    logic [PWM_WIDTH-1:0] duty_red;
    logic [PWM_WIDTH-1:0] own_duty;
    logic [PWM_WIDTH-1:0] up_duty;
    logic [PWM_WIDTH-1:0] dn_duty;
    logic                 wrap_tick;

    assign wrap_tick = pwm_en && (pwm_cnt == DUTY_MAX);
    assign own_duty  = (cur == RED) ? duty_red : duty_blue;
    assign up_duty   = PWM_WIDTH'(sat_add(32'(own_duty), FADE_STEP, 32'(DUTY_MAX)));
    assign dn_duty   = PWM_WIDTH'(sat_sub(32'(own_duty), FADE_STEP));
    assign busy      = (state == FADE_IN) || (state == FADE_OUT);
    assign cur_color = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= NONE;
            err     <= 1'b0;
        end else begin
            err <= !is_legal(color_in);
            if (is_legal(color_in)) begin
                pending <= color_t'(color_in);
            end
        end
    end

    // Counter, FSM and duties advance together and freeze while pwm_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= NONE;
            pwm_cnt   <= '0;
            duty_blue <= '0;
            duty_red  <= '0;
        end else if (pwm_en) begin
            pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
            case (state)
                IDLE: begin
                    if (pending != NONE) begin
                        cur   <= pending;
                        state <= FADE_IN;
                    end
                end
                FADE_IN: begin
                    if (wrap_tick) begin
                        if (cur == RED) duty_red  <= up_duty;
                        else            duty_blue <= up_duty;
                        if (up_duty == DUTY_MAX) state <= STEADY;
                    end
                end
                STEADY: begin
                    if (pending != cur) state <= FADE_OUT;
                end
                FADE_OUT: begin
                    // A reversal resumes ramping up from wherever the duty is now.
                    if (pending == cur) begin
                        state <= FADE_IN;
                    end else if (wrap_tick) begin
                        if (cur == RED) duty_red  <= dn_duty;
                        else            duty_blue <= dn_duty;
                        if (dn_duty == '0) begin
                            cur   <= pending;
                            state <= FADE_IN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    led_pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_blue (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .duty    (duty_blue),
        .pwm_en  (pwm_en),
        .led     (led_blue)
    );

    led_pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_red (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .duty    (duty_red),
        .pwm_en  (pwm_en),
        .led     (led_red)
    );

endmodule

// File: tb/tb_color_led_driver.sv
// Directed bench for color_led_driver with PWM_WIDTH=4, FADE_STEP=4 (16-cycle PWM period).
module tb_color_led_driver;

    logic       clk;
    logic       rst_n;
    logic [1:0] color_in;
    logic       pwm_en;
    logic       led_blue;
    logic       led_red;
    logic [1:0] cur_color;
    logic       busy;
    logic       err;

    int errors = 0;
    int checks = 0;
    int cnt_b, cnt_r, overlap;

    color_led_driver #(.PWM_WIDTH(4), .FADE_STEP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .color_in  (color_in),
        .pwm_en    (pwm_en),
        .led_blue  (led_blue),
        .led_red   (led_red),
        .cur_color (cur_color),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] color;
        int         exp_b;
        int         exp_r;
        int         exp_cur;
        int         exp_busy;
    } vec_t;

    vec_t vecs[32];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (led_blue) cnt_b++;
        if (led_red) cnt_r++;
        if (led_blue && led_red) overlap++;
    endtask

    task automatic set_vec(input int i, input logic [1:0] c, input int b, input int r,
                           input int cur, input int bz);
        vecs[i].color    = c;
        vecs[i].exp_b    = b;
        vecs[i].exp_r    = r;
        vecs[i].exp_cur  = cur;
        vecs[i].exp_busy = bz;
    endtask

    initial begin
        int prev_b, prev_r;

        // One entry per PWM period: duties/cur/busy after the wrap closing that period.
        set_vec(0, 2'd1, 4, 0, 1, 1);   set_vec(1, 2'd1, 8, 0, 1, 1);
        set_vec(2, 2'd1, 12, 0, 1, 1);  set_vec(3, 2'd1, 15, 0, 1, 0);
        set_vec(4, 2'd2, 11, 0, 1, 1);  set_vec(5, 2'd2, 7, 0, 1, 1);
        set_vec(6, 2'd2, 3, 0, 1, 1);   set_vec(7, 2'd2, 0, 0, 2, 1);
        set_vec(8, 2'd2, 0, 4, 2, 1);   set_vec(9, 2'd2, 0, 8, 2, 1);
        set_vec(10, 2'd2, 0, 12, 2, 1); set_vec(11, 2'd2, 0, 15, 2, 0);
        set_vec(12, 2'd1, 0, 11, 2, 1); set_vec(13, 2'd1, 0, 7, 2, 1);
        set_vec(14, 2'd1, 0, 3, 2, 1);  set_vec(15, 2'd1, 0, 0, 1, 1);
        set_vec(16, 2'd1, 4, 0, 1, 1);  set_vec(17, 2'd1, 8, 0, 1, 1);
        set_vec(18, 2'd1, 12, 0, 1, 1); set_vec(19, 2'd1, 15, 0, 1, 0);
        set_vec(20, 2'd2, 11, 0, 1, 1); set_vec(21, 2'd2, 7, 0, 1, 1);
        set_vec(22, 2'd1, 11, 0, 1, 1); set_vec(23, 2'd1, 15, 0, 1, 0);
        set_vec(24, 2'd2, 11, 0, 1, 1); set_vec(25, 2'd2, 7, 0, 1, 1);
        set_vec(26, 2'd2, 3, 0, 1, 1);  set_vec(27, 2'd2, 0, 0, 2, 1);
        set_vec(28, 2'd2, 0, 4, 2, 1);  set_vec(29, 2'd2, 0, 8, 2, 1);
        set_vec(30, 2'd2, 0, 12, 2, 1); set_vec(31, 2'd2, 0, 15, 2, 0);

        rst_n    = 1'b0;
        color_in = 2'd1;
        pwm_en   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led_blue", int'(led_blue), 0);
        check("rst_led_red", int'(led_red), 0);
        check("rst_cur_color", int'(cur_color), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;

        // Fade sequences: LED high-count over a period equals the duty held during it.
        prev_b = 0;
        prev_r = 0;
        for (int i = 0; i < 32; i++) begin
            color_in = vecs[i].color;
            cnt_b = 0; cnt_r = 0; overlap = 0;
            repeat (16) tick();
            check($sformatf("v%0d_duty_blue", i), int'(dut.duty_blue), vecs[i].exp_b);
            check($sformatf("v%0d_duty_red", i), int'(dut.duty_red), vecs[i].exp_r);
            check($sformatf("v%0d_cur_color", i), int'(cur_color), vecs[i].exp_cur);
            check($sformatf("v%0d_busy", i), int'(busy), vecs[i].exp_busy);
            check($sformatf("v%0d_blue_count", i), cnt_b, prev_b);
            check($sformatf("v%0d_red_count", i), cnt_r, prev_r);
            check($sformatf("v%0d_overlap", i), overlap, 0);
            prev_b = vecs[i].exp_b;
            prev_r = vecs[i].exp_r;
        end

        // Illegal codes during STEADY Red: 3 then 0,0 give three err cycles.
        color_in = 2'd3;
        tick();
        check("ill_err_0", int'(err), 1);
        color_in = 2'd0;
        tick();
        check("ill_err_1", int'(err), 1);
        tick();
        check("ill_err_2", int'(err), 1);
        check("ill_pending", int'(dut.pending), 2);
        check("ill_cur", int'(cur_color), 2);
        check("ill_busy", int'(busy), 0);
        color_in = 2'd2;
        tick();
        check("ill_err_clear", int'(err), 0);
        tick();
        check("ill_err_stay", int'(err), 0);
        check("ill_duty_red", int'(dut.duty_red), 15);
        repeat (11) tick();

        // Freeze mid-FADE_OUT Red.
        color_in = 2'd1;
        repeat (16) tick();
        check("frz_pre_duty", int'(dut.duty_red), 11);
        check("frz_pre_busy", int'(busy), 1);
        repeat (5) tick();
        pwm_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0 || i == 19) begin
                check($sformatf("frz%0d_led_red", i), int'(led_red), 0);
                check($sformatf("frz%0d_led_blue", i), int'(led_blue), 0);
                check($sformatf("frz%0d_cnt", i), int'(dut.pwm_cnt), 5);
                check($sformatf("frz%0d_duty", i), int'(dut.duty_red), 11);
                check($sformatf("frz%0d_busy", i), int'(busy), 1);
            end
        end
        pwm_en = 1'b1;
        repeat (10) tick();
        check("resume_before_wrap", int'(dut.duty_red), 11);
        tick();
        check("resume_after_wrap", int'(dut.duty_red), 7);

        // Reverse back to Red, then reset asynchronously while fading in.
        color_in = 2'd2;
        repeat (4) tick();
        check("arst_pre_busy", int'(busy), 1);
        check("arst_pre_cur", int'(cur_color), 2);
        check("arst_pre_led_red", int'(led_red), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_led_red", int'(led_red), 0);
        check("arst_led_blue", int'(led_blue), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_cur", int'(cur_color), 0);
        check("arst_err", int'(err), 0);
        repeat (2) @(posedge clk);
        #1;
        check("arst_duty_red", int'(dut.duty_red), 0);
        check("arst_cnt", int'(dut.pwm_cnt), 0);
        rst_n = 1'b1;
        tick();
        check("restart_idle_cur", int'(cur_color), 0);
        check("restart_idle_busy", int'(busy), 0);
        tick();
        check("restart_fadein_cur", int'(cur_color), 2);
        check("restart_fadein_busy", int'(busy), 1);
        check("restart_duty_zero", int'(dut.duty_red), 0);
        repeat (14) tick();
        check("restart_first_step", int'(dut.duty_red), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/color_led_driver.md
Name: color_led_driver

Overview:
- Downstream stage of the Color state machine; consumes its 2-bit registered output code (2'h1 = Blue, 2'h2 = Red).
- Drives two PWM LED channels and cross-fades between colors: the old channel ramps down, then the new channel ramps up.
- Reports busy during fades and flags illegal codes.

Parameters:
- PWM_WIDTH, 8: width of the PWM counter and duty registers; DUTY_MAX = 2^PWM_WIDTH-1.
- FADE_STEP, 16: duty increment/decrement applied once per PWM period during a fade.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- color_in  input  2  color code from the upstream FSM: 2'h1 Blue, 2'h2 Red; 2'h0 and 2'h3 are illegal.
- pwm_en  input  1  enables the PWM counter and fade engine.
- led_blue  output  1  Blue PWM drive, registered.
- led_red  output  1  Red PWM drive, registered.
- cur_color  output  2  color currently owning (or fading into) the LEDs; 2'h0 = none.
- busy  output  1  high while in FADE_OUT or FADE_IN.
- err  output  1  one-cycle pulse on an illegal color_in.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; pwm_cnt, both duties, pending, cur_color = 0.
  - All outputs 0.
- PWM counter:
  - pwm_cnt (PWM_WIDTH bits) increments each cycle when pwm_en=1 and wraps DUTY_MAX -> 0.
  - wrap_tick = pwm_en && pwm_cnt==DUTY_MAX.
- LED outputs:
  - led_x <= pwm_en && (pwm_cnt < duty_x); one-cycle latency from the counter.
  - pwm_en=0: counter, duties and FSM frozen; LEDs 0 from the next edge.
- Input sampling, every cycle regardless of pwm_en:
  - color_in in {1,2} -> pending <= color_in.
  - color_in in {0,3} -> pending unchanged; err <= 1 for one cycle. Sustained illegal input gives err high each cycle.
- Duty arithmetic:
  - Up: sum computed in PWM_WIDTH+1 bits, saturates at DUTY_MAX.
  - Down: saturates at 0 (no wrap).
  - Duties change only on wrap_tick.
- FSM, states IDLE, FADE_IN, STEADY, FADE_OUT; all transitions on a clock edge.
- IDLE:
  - On pending valid: cur_color <= pending, go to FADE_IN.
  - The first valid code seen after reset goes to FADE_IN the next cycle.
- FADE_IN:
  - On wrap_tick, duty[cur_color] += FADE_STEP.
  - When the saturated value equals DUTY_MAX, go to STEADY on the same edge.
- STEADY:
  - Holds duty[cur_color]=DUTY_MAX.
  - pending != cur_color -> FADE_OUT.
- FADE_OUT:
  - On wrap_tick, duty[cur_color] -= FADE_STEP.
  - When it reaches 0: cur_color <= pending, go to FADE_IN.
  - If pending returns to cur_color mid-fade: go to FADE_IN for the same color and ramp back up from the current duty, no dip to 0.
- Change during FADE_IN: completes to STEADY; STEADY then detects the mismatch next cycle.
- Invariant: at most one duty is nonzero; the non-owning duty is held at 0.
- busy is combinational from state.
- Reset mid-fade: everything returns to IDLE immediately; LEDs low asynchronously.
- Fade timing: full ramp = ceil(DUTY_MAX/FADE_STEP) PWM periods.

Decomposition:
- Package color_led_pkg:
  - color_t enum (NONE=2'h0, BLUE=2'h1, RED=2'h2), shared with the Color FSM's output encoding.
  - led_state_t enum (IDLE, FADE_IN, STEADY, FADE_OUT).
  - Saturating add/sub functions.
- Sub-module led_pwm_channel, instantiated twice:
  - Inputs: clk, rst_n, pwm_cnt, duty, pwm_en.
  - Output: registered led.
- The top level holds the counter, FSM and duty registers.

Test Plan (PWM_WIDTH=4, FADE_STEP=4, DUTY_MAX=15; ramp is 4 periods = 64 cycles):
- Reset then color_in=1, pwm_en=1:
  - IDLE -> FADE_IN next cycle; cur_color=1, busy=1.
  - duty_blue steps 4,8,12,15 at wraps.
  - STEADY after 4th wrap; busy=0; led_blue high 15 of every 16 cycles; led_red never high.
- From STEADY Blue, color_in=2:
  - FADE_OUT: duty_blue 11,7,3,0.
  - Then cur_color=2; FADE_IN with duty_red 4,8,12,15; STEADY.
  - led_blue and led_red never high in the same cycle.
- Reversal: in FADE_OUT Blue at duty_blue=7, color_in back to 1:
  - Next cycle FADE_IN Blue; duty_blue 11,15; STEADY.
  - cur_color stays 1 throughout.
- Illegal input: color_in=3 for 1 cycle, then 0 for 2 cycles during STEADY Red:
  - err high for exactly those 3 cycles.
  - pending, cur_color and state unchanged.
- pwm_en=0 mid-fade for 20 cycles:
  - pwm_cnt and duty frozen; LEDs 0.
  - On re-enable, the fade resumes from the frozen values.
- rst_n asserted mid-FADE_IN Red, asynchronously between edges:
  - LEDs, busy, cur_color and err go 0 immediately.
  - After release with color_in=2, the sequence restarts from IDLE with duty_red=0.
